// File: rtl/nested_loop_counter.sv
// Nested loop index generator: NDim counters, dimension 0 innermost, each
// counting 0..bound inclusive, advanced one iteration per accepted step.
module nested_loop_counter #(
    parameter int unsigned DWidth = 16,
    parameter int unsigned NDim   = 3
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         start_i,
    input  logic                         clear_i,
    input  logic                         step_i,
    input  logic [NDim-1:0][DWidth-1:0]  bound_i,
    output logic                         busy_o,
    output logic [NDim-1:0][DWidth-1:0]  idx_o,
    output logic [NDim-1:0]              wrap_o,
    output logic                         last_o,
    output logic                         done_o
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e                        state_q, state_d;
    logic [NDim-1:0][DWidth-1:0]   bound_q, bound_d;
    logic [NDim-1:0][DWidth-1:0]   idx_q, idx_d;
    logic [NDim-1:0]               wrap_q, wrap_d;
    logic                          done_q, done_d;
    logic [NDim-1:0]               at_bound;
    logic [NDim-1:0]               carry;

    // A dimension advances only when every inner dimension sits at its bound.
    always_comb begin
        at_bound = '0;
        carry    = '0;
        for (int unsigned k = 0; k < NDim; k++) begin
            at_bound[k] = (idx_q[k] == bound_q[k]);
        end
        carry[0] = 1'b1;
        for (int unsigned k = 1; k < NDim; k++) begin
            carry[k] = carry[k-1] & at_bound[k-1];
        end
    end

    assign last_o = (state_q == RUN) && (&at_bound);
    assign busy_o = (state_q == RUN);
    assign idx_o  = idx_q;
    assign wrap_o = wrap_q;
    assign done_o = done_q;

    always_comb begin
        state_d = state_q;
        bound_d = bound_q;
        idx_d   = idx_q;
        wrap_d  = '0;
        done_d  = 1'b0;
        if (clear_i) begin
            state_d = IDLE;
            bound_d = '0;
            idx_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start_i) begin
                        bound_d = bound_i;
                        idx_d   = '0;
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (step_i) begin
                        for (int unsigned k = 0; k < NDim; k++) begin
                            if (carry[k]) begin
                                if (at_bound[k]) begin
                                    idx_d[k]  = '0;
                                    wrap_d[k] = 1'b1;
                                end else begin
                                    idx_d[k] = idx_q[k] + DWidth'(1);
                                end
                            end
                        end
                        // Final iteration: every dimension wraps and the nest ends.
                        if (last_o) begin
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            bound_q <= '0;
            idx_q   <= '0;
            wrap_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bound_q <= bound_d;
            idx_q   <= idx_d;
            wrap_q  <= wrap_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_nested_loop_counter.sv
// Directed bench for nested_loop_counter: a 3-D 16-bit instance and a
// 1-D 4-bit instance sharing clock and reset.
module tb_nested_loop_counter;

    logic               clk_i = 1'b0;
    logic               rst_ni;

    logic               start, clear, step;
    logic [2:0][15:0]   bound;
    logic               busy, last, done;
    logic [2:0][15:0]   idx;
    logic [2:0]         wrap;

    logic               start1, clear1, step1;
    logic [0:0][3:0]    bound1;
    logic               busy1, last1, done1;
    logic [0:0][3:0]    idx1;
    logic [0:0]         wrap1;

    logic               last_s, last1_s;
    int                 n_pass = 0;
    int                 n_total = 0;

    always #5 clk_i = ~clk_i;

    nested_loop_counter #(.DWidth(16), .NDim(3)) u_dut3 (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start), .clear_i(clear),
        .step_i(step), .bound_i(bound), .busy_o(busy), .idx_o(idx),
        .wrap_o(wrap), .last_o(last), .done_o(done)
    );

    nested_loop_counter #(.DWidth(4), .NDim(1)) u_dut1 (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start1), .clear_i(clear1),
        .step_i(step1), .bound_i(bound1), .busy_o(busy1), .idx_o(idx1),
        .wrap_o(wrap1), .last_o(last1), .done_o(done1)
    );

    typedef struct {
        logic             start, clear, step;
        logic [2:0][15:0] bnd;
        logic             last_pre;
        logic [2:0][15:0] idx;
        logic [2:0]       wrap;
        logic             done, busy;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    // Drive inputs at negedge, capture combinational last_o, then step past posedge.
    task automatic drive(input logic s, input logic c, input logic st);
        @(negedge clk_i);
        start = s; clear = c; step = st;
        #1 last_s = last;
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive1(input logic s, input logic c, input logic st);
        @(negedge clk_i);
        start1 = s; clear1 = c; step1 = st;
        #1 last1_s = last1;
        @(posedge clk_i);
        #1;
    endtask

    function automatic vec_t mk(input logic s, input logic c, input logic st,
                                input logic [2:0][15:0] b, input logic lp,
                                input logic [2:0][15:0] ix, input logic [2:0] w,
                                input logic d, input logic bz);
        vec_t v;
        v.start = s; v.clear = c; v.step = st; v.bnd = b; v.last_pre = lp;
        v.idx = ix; v.wrap = w; v.done = d; v.busy = bz;
        return v;
    endfunction

    initial begin
        logic [2:0][15:0] b000, b003, b555, b121, exp_idx;
        logic [2:0]       exp_wrap;
        int               n;

        b000 = '0;
        b003 = {16'd0, 16'd0, 16'd3};
        b555 = {16'd5, 16'd5, 16'd5};
        b121 = {16'd1, 16'd2, 16'd1};

        // All-zero bounds, clear priority, then bounds {3,0,0} with gapped steps.
        vecs[0]  = mk(1, 0, 0, b000, 0, '0, 3'b000, 0, 1);
        vecs[1]  = mk(0, 0, 0, b000, 1, '0, 3'b000, 0, 1);
        vecs[2]  = mk(0, 0, 1, b000, 1, '0, 3'b111, 1, 0);
        vecs[3]  = mk(1, 0, 1, b000, 0, '0, 3'b000, 0, 1);
        vecs[4]  = mk(0, 1, 1, b000, 1, '0, 3'b000, 0, 0);
        vecs[5]  = mk(1, 0, 0, b003, 0, '0, 3'b000, 0, 1);
        vecs[6]  = mk(0, 0, 1, b555, 0, {16'd0, 16'd0, 16'd1}, 3'b000, 0, 1);
        vecs[7]  = mk(0, 0, 0, b555, 0, {16'd0, 16'd0, 16'd1}, 3'b000, 0, 1);
        vecs[8]  = mk(0, 0, 1, b555, 0, {16'd0, 16'd0, 16'd2}, 3'b000, 0, 1);
        vecs[9]  = mk(1, 0, 0, b555, 0, {16'd0, 16'd0, 16'd2}, 3'b000, 0, 1);
        vecs[10] = mk(0, 0, 1, b555, 0, {16'd0, 16'd0, 16'd3}, 3'b000, 0, 1);
        vecs[11] = mk(0, 0, 0, b555, 1, {16'd0, 16'd0, 16'd3}, 3'b000, 0, 1);
        vecs[12] = mk(0, 0, 1, b555, 1, '0, 3'b111, 1, 0);
        vecs[13] = mk(0, 0, 1, b555, 0, '0, 3'b000, 0, 0);

        rst_ni = 1'b0;
        start = 0; clear = 0; step = 0; bound = '0;
        start1 = 0; clear1 = 0; step1 = 0; bound1 = '0;
        #2;
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset idx", 64'(idx), 64'd0);
        chk("reset wrap", 64'(wrap), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        chk("reset last", 64'(last), 64'd0);
        chk("reset idx1", 64'(idx1), 64'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        for (int i = 0; i < 14; i++) begin
            bound = vecs[i].bnd;
            drive(vecs[i].start, vecs[i].clear, vecs[i].step);
            chk($sformatf("vec%0d last", i), 64'(last_s), 64'(vecs[i].last_pre));
            chk($sformatf("vec%0d idx", i), 64'(idx), 64'(vecs[i].idx));
            chk($sformatf("vec%0d wrap", i), 64'(wrap), 64'(vecs[i].wrap));
            chk($sformatf("vec%0d done", i), 64'(done), 64'(vecs[i].done));
            chk($sformatf("vec%0d busy", i), 64'(busy), 64'(vecs[i].busy));
        end

        // Bounds {1,2,1}: 12 steps, dim0 fastest.
        bound = b121;
        drive(1, 0, 0);
        chk("n121 start busy", 64'(busy), 64'd1);
        bound = b555;
        for (int s = 1; s <= 12; s++) begin
            drive(0, 0, 1);
            n = s % 12;
            exp_idx  = {16'(n / 6), 16'((n / 2) % 3), 16'(n % 2)};
            exp_wrap = {s % 12 == 0, s % 6 == 0, s % 2 == 0};
            chk($sformatf("n121 s%0d last", s), 64'(last_s), 64'(s == 12));
            chk($sformatf("n121 s%0d idx", s), 64'(idx), 64'(exp_idx));
            chk($sformatf("n121 s%0d wrap", s), 64'(wrap), 64'(exp_wrap));
            chk($sformatf("n121 s%0d done", s), 64'(done), 64'(s == 12));
            chk($sformatf("n121 s%0d busy", s), 64'(busy), 64'(s < 12));
        end

        // Clear mid-nest at idx {0,1,1} with step also high.
        bound = b121;
        drive(1, 0, 0);
        for (int s = 0; s < 3; s++) drive(0, 0, 1);
        chk("clr pre idx", 64'(idx), 64'({16'd0, 16'd1, 16'd1}));
        drive(0, 1, 1);
        chk("clr idx", 64'(idx), 64'd0);
        chk("clr done", 64'(done), 64'd0);
        chk("clr wrap", 64'(wrap), 64'd0);
        chk("clr busy", 64'(busy), 64'd0);
        drive(0, 0, 1);
        drive(0, 0, 1);
        chk("clr step ignored idx", 64'(idx), 64'd0);
        chk("clr step ignored busy", 64'(busy), 64'd0);

        // Asynchronous reset mid-nest while wrap_o[0] is high.
        drive(1, 0, 0);
        drive(0, 0, 1);
        drive(0, 0, 1);
        chk("rst pre wrap", 64'(wrap), 64'b001);
        @(negedge clk_i);
        start = 0; step = 0;
        #2 rst_ni = 1'b0;
        #1;
        chk("rst async idx", 64'(idx), 64'd0);
        chk("rst async wrap", 64'(wrap), 64'd0);
        chk("rst async busy", 64'(busy), 64'd0);
        chk("rst async done", 64'(done), 64'd0);
        @(posedge clk_i);
        #1 chk("rst held done", 64'(done), 64'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        drive(0, 0, 1);
        chk("rst wait busy", 64'(busy), 64'd0);
        drive(1, 0, 0);
        chk("rst restart busy", 64'(busy), 64'd1);
        chk("rst restart idx", 64'(idx), 64'd0);
        drive(0, 0, 1);
        chk("rst restart step", 64'(idx), 64'd1);

        // 1-D 4-bit full range with a start during RUN and a restart in the done cycle.
        bound1 = 4'd15;
        drive1(1, 0, 0);
        chk("d1 start busy", 64'(busy1), 64'd1);
        bound1 = 4'd2;
        for (int s = 1; s <= 16; s++) begin
            drive1(s == 5, 0, 1);
            chk($sformatf("d1 s%0d last", s), 64'(last1_s), 64'(s == 16));
            chk($sformatf("d1 s%0d idx", s), 64'(idx1), 64'(s % 16));
            chk($sformatf("d1 s%0d wrap", s), 64'(wrap1), 64'(s == 16));
            chk($sformatf("d1 s%0d done", s), 64'(done1), 64'(s == 16));
            chk($sformatf("d1 s%0d busy", s), 64'(busy1), 64'(s < 16));
        end
        bound1 = 4'd15;
        drive1(1, 0, 0);
        chk("d1 restart busy", 64'(busy1), 64'd1);
        chk("d1 restart done", 64'(done1), 64'd0);
        drive1(0, 0, 1);
        chk("d1 restart idx", 64'(idx1), 64'd1);
        drive1(0, 1, 0);
        chk("d1 clear busy", 64'(busy1), 64'd0);
        chk("d1 clear idx", 64'(idx1), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
